// File: rtl/ocx_dlx_tx_pkg.sv
// Shared definitions for the DLx TX lane queue: training-set headers, width-mode
// encodings and the per-lane output bit-order transform.
package ocx_dlx_tx_pkg;

  localparam logic [15:0] TsHdrTs1    = 16'h4B4A;
  localparam logic [15:0] TsHdrTs2    = 16'h4B45;
  localparam logic [15:0] TsHdrTs3    = 16'h4B41;
  localparam logic [15:0] TsHdrDeskew = 16'h4B1E;

  typedef enum logic [1:0] {
    ModeFull    = 2'b00,
    ModeHalf    = 2'b01,
    ModeQuarter = 2'b10,
    ModeRsvd    = 2'b11
  } width_mode_e;

  // Byte-order reversal followed by bit reversal inside each byte is a full 64-bit flip.
  function automatic logic [63:0] lane_reverse(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) begin
      r[i] = w[63-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ocx_dlx_tx_que_fifo.sv
// Synchronous FIFO with flush; pointers wrap naturally because Depth is a power of two.
module ocx_dlx_tx_que_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [Width-1:0]             push_data,
  input  logic                         pop,
  output logic [Width-1:0]             head_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth+1);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full      = (count_q == CntW'(Depth));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ocx_dlx_tx_lane_que.sv
// DLx TX lane queue: buffers flit beats, serialises them for degraded link widths,
// injects TS/deskew training beats and scrambles each lane toward the gearbox.
module ocx_dlx_tx_lane_que
  import ocx_dlx_tx_pkg::*;
#(
  parameter int unsigned LANES    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TS_CNT_W = 5
) (
  input  logic                dlx_clk,
  input  logic                dlx_reset_n,
  input  logic                ctl_que_reset,
  input  logic                flt_que_valid,
  input  logic [LANES*64-1:0] flt_que_data,
  output logic                flt_que_ready,
  input  logic [1:0]          ctl_que_width_mode,
  input  logic                ctl_que_tx_ts0,
  input  logic                ctl_que_tx_ts1,
  input  logic                ctl_que_tx_ts2,
  input  logic                ctl_que_tx_ts3,
  input  logic [15:0]         ctl_que_good_lanes,
  input  logic [23:0]         ctl_que_deskew,
  input  logic [LANES*64-1:0] ctl_que_lane_scrambler,
  input  logic                gb_que_ready,
  output logic                que_gb_valid,
  output logic [LANES*64-1:0] que_gb_data,
  output logic                que_deskew_sent
);

  localparam int unsigned W    = LANES * 64;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic                training, load, push, pop, flush, is_deskew;
  logic                rdy_en_q;
  logic                fifo_full, fifo_empty;
  logic [CntW-1:0]     fifo_count;
  logic [W-1:0]        fifo_head, flit_beat, ts_beat;
  logic [W-1:0]        data_q, data_d;
  logic                valid_q, valid_d, deskew_q, deskew_d;
  logic [TS_CNT_W-1:0] ts_cnt_q, ts_cnt_d;
  logic [1:0]          beat_cnt_q, beat_cnt_d, last_beat;
  width_mode_e         active_mode_q, active_mode_d, mode_eff;
  int unsigned         grp;
  logic                unused_deskew_lsb, unused_fifo_count;

  assign unused_deskew_lsb = ^ctl_que_deskew[4:0];
  assign unused_fifo_count = ^fifo_count;

  assign training      = ctl_que_tx_ts0 | ctl_que_tx_ts1 | ctl_que_tx_ts2 | ctl_que_tx_ts3;
  assign flt_que_ready = rdy_en_q & ~fifo_full & ~training & ~ctl_que_reset;
  assign push          = flt_que_valid & flt_que_ready;
  assign load          = ~valid_q | gb_que_ready;
  assign flush         = training | ctl_que_reset;
  assign is_deskew     = &ts_cnt_q;
  assign pop           = load & ~flush & ~fifo_empty & (beat_cnt_q == last_beat);

  // A new width only takes effect between entries, so an entry never changes shape mid-way.
  assign mode_eff = (beat_cnt_q == 2'd0) ? width_mode_e'(ctl_que_width_mode) : active_mode_q;

  ocx_dlx_tx_que_fifo #(
    .Width (W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk       (dlx_clk),
    .rst_n     (dlx_reset_n),
    .flush     (flush),
    .push      (push),
    .push_data (flt_que_data),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    unique case (mode_eff)
      ModeHalf:    begin last_beat = 2'd1; grp = LANES / 2; end
      ModeQuarter: begin last_beat = 2'd3; grp = LANES / 4; end
      default:     begin last_beat = 2'd0; grp = LANES;     end
    endcase
  end

  always_comb begin
    int unsigned src;
    src       = 0;
    flit_beat = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      src = 32'(beat_cnt_q) * grp + j;
      if (j < grp && src < LANES) flit_beat[64*j +: 64] = fifo_head[64*src +: 64];
    end
  end

  always_comb begin
    ts_beat = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (is_deskew) begin
        ts_beat[64*i +: 64] = {TsHdrDeskew, {3{8'h1E}}, ctl_que_deskew[23:5], 2'b00, 3'(i)};
      end else if (ctl_que_tx_ts1) begin
        ts_beat[64*i +: 64] = {TsHdrTs1, {6{8'h4A}}};
      end else if (ctl_que_tx_ts2) begin
        ts_beat[64*i +: 64] = {TsHdrTs2, {4{8'h45}}, ctl_que_good_lanes};
      end else if (ctl_que_tx_ts3) begin
        ts_beat[64*i +: 64] = {TsHdrTs3, {4{8'h41}}, ctl_que_good_lanes};
      end
    end
  end

  always_comb begin
    valid_d       = valid_q;
    data_d        = data_q;
    deskew_d      = deskew_q;
    ts_cnt_d      = ts_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    active_mode_d = mode_eff;
    if (ctl_que_reset) begin
      valid_d    = 1'b0;
      deskew_d   = 1'b0;
      ts_cnt_d   = '0;
      beat_cnt_d = '0;
    end else begin
      if (training) beat_cnt_d = '0;
      if (load) begin
        if (training) begin
          valid_d  = 1'b1;
          data_d   = ts_beat;
          deskew_d = is_deskew;
          ts_cnt_d = ts_cnt_q + TS_CNT_W'(1);
        end else if (!fifo_empty) begin
          valid_d    = 1'b1;
          data_d     = flit_beat;
          deskew_d   = 1'b0;
          beat_cnt_d = (beat_cnt_q == last_beat) ? 2'd0 : beat_cnt_q + 2'd1;
        end else begin
          valid_d  = 1'b0;
          deskew_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge dlx_clk or negedge dlx_reset_n) begin
    if (!dlx_reset_n) begin
      rdy_en_q      <= 1'b0;
      valid_q       <= 1'b0;
      data_q        <= '0;
      deskew_q      <= 1'b0;
      ts_cnt_q      <= '0;
      beat_cnt_q    <= '0;
      active_mode_q <= ModeFull;
    end else begin
      rdy_en_q      <= 1'b1;
      valid_q       <= valid_d;
      data_q        <= data_d;
      deskew_q      <= deskew_d;
      ts_cnt_q      <= ts_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      active_mode_q <= active_mode_d;
    end
  end

  assign que_gb_valid    = valid_q;
  assign que_deskew_sent = valid_q & gb_que_ready & deskew_q;

  always_comb begin
    que_gb_data = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      que_gb_data[64*l +: 64] = lane_reverse(data_q[64*l +: 64]) ^
                                ctl_que_lane_scrambler[64*l +: 64];
    end
  end

endmodule
